// File: rtl/short_pair_mac_pkg.sv
// Shared types and widths for the short-pair multiply/accumulate read master.
// Holds the FSM state encoding and the short-to-product sign extension helper.
package short_pair_mac_pkg;

    localparam int SHORT_W = 16;
    localparam int PROD_W  = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_DATA = 3'd2,
        ST_DRAIN     = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    function automatic logic signed [PROD_W-1:0] sextShort(input logic [SHORT_W-1:0] v);
        return {{(PROD_W-SHORT_W){v[SHORT_W-1]}}, v};
    endfunction

endpackage

// File: rtl/short_pair_mac_mul_acc.sv
// Two-stage signed multiply/accumulate: stage 1 registers a*b, stage 2 adds it
// into a wide accumulator. Busy while either stage holds a valid term.
module short_mul_acc
    import short_pair_mac_pkg::*;
#(
    parameter int ACC_WIDTH = 40
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_valid,
    input  logic                 i_clr,
    input  logic [SHORT_W-1:0]   i_a,
    input  logic [SHORT_W-1:0]   i_b,
    output logic                 o_busy,
    output logic [ACC_WIDTH-1:0] o_acc
);

    logic signed [PROD_W-1:0]    w_a;
    logic signed [PROD_W-1:0]    w_b;
    logic signed [PROD_W-1:0]    w_prod;
    logic signed [ACC_WIDTH-1:0] w_prodExt;

    logic signed [PROD_W-1:0]    r_prod;
    logic                        r_s1Valid;
    logic                        r_s2Valid;
    logic signed [ACC_WIDTH-1:0] r_acc;

    assign w_a       = sextShort(i_a);
    assign w_b       = sextShort(i_b);
    assign w_prod    = w_a * w_b;
    assign w_prodExt = {{(ACC_WIDTH-PROD_W){r_prod[PROD_W-1]}}, r_prod};

    // Stage 2 valid only flags the cycle after an add, so busy covers the full drain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prod    <= '0;
            r_s1Valid <= 1'b0;
            r_s2Valid <= 1'b0;
            r_acc     <= '0;
        end else if (i_clr) begin
            r_s1Valid <= 1'b0;
            r_s2Valid <= 1'b0;
            r_acc     <= '0;
        end else begin
            r_s1Valid <= i_valid;
            r_s2Valid <= r_s1Valid;
            if (i_valid) begin
                r_prod <= w_prod;
            end
            if (r_s1Valid) begin
                r_acc <= r_acc + w_prodExt;
            end
        end
    end

    assign o_busy = r_s1Valid | r_s2Valid;
    assign o_acc  = r_acc;

endmodule

// File: rtl/short_pair_mac.sv
// Avalon-MM read master that fetches a block of words, one read outstanding,
// and accumulates the product of the two signed shorts packed in each word.
module short_pair_mac
    import short_pair_mac_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 24,
    parameter int CNT_WIDTH  = 5,
    parameter int ACC_WIDTH  = 40
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  word_count,
    output logic                  busy,
    output logic                  done,
    output logic [ACC_WIDTH-1:0]  result,
    output logic [ADDR_WIDTH-1:0] m_address,
    output logic                  m_read,
    input  logic                  m_waitrequest,
    input  logic [DATA_WIDTH-1:0] m_readdata,
    input  logic                  m_readdatavalid
);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [CNT_WIDTH-1:0]  r_remaining;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_read;
    logic [ACC_WIDTH-1:0]  r_result;

    logic                  w_capture;
    logic                  w_clr;
    logic                  w_macBusy;
    logic [ACC_WIDTH-1:0]  w_acc;

    // Read data is only meaningful in WAIT_DATA; the slave may hold valid high forever.
    assign w_capture = (r_state == ST_WAIT_DATA) && m_readdatavalid;
    assign w_clr     = (r_state == ST_IDLE) && start;

    short_mul_acc #(
        .ACC_WIDTH(ACC_WIDTH)
    ) u_mulAcc (
        .clk     (clk),
        .reset_n (reset_n),
        .i_valid (w_capture),
        .i_clr   (w_clr),
        .i_a     (m_readdata[SHORT_W-1:0]),
        .i_b     (m_readdata[2*SHORT_W-1:SHORT_W]),
        .o_busy  (w_macBusy),
        .o_acc   (w_acc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_read      <= 1'b0;
            r_result    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_busy      <= 1'b1;
                        r_addr      <= {base_addr[ADDR_WIDTH-1:2], 2'b00};
                        r_remaining <= word_count;
                        if (word_count != '0) begin
                            r_read  <= 1'b1;
                            r_state <= ST_ISSUE;
                        end else begin
                            r_result <= '0;
                            r_done   <= 1'b1;
                            r_state  <= ST_DONE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (!m_waitrequest) begin
                        r_read  <= 1'b0;
                        r_state <= ST_WAIT_DATA;
                    end
                end
                ST_WAIT_DATA: begin
                    if (m_readdatavalid) begin
                        r_addr      <= r_addr + ADDR_WIDTH'(4);
                        r_remaining <= r_remaining - CNT_WIDTH'(1);
                        if (r_remaining == CNT_WIDTH'(1)) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_read  <= 1'b1;
                            r_state <= ST_ISSUE;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!w_macBusy) begin
                        r_done   <= 1'b1;
                        r_result <= w_acc;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;
    assign m_address = r_addr;
    assign m_read    = r_read;

endmodule

// File: tb/tb_short_pair_mac.sv
// Directed bench for short_pair_mac with a small scratch-RAM Avalon slave model.
module tb_short_pair_mac;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [23:0] base_addr;
    logic [4:0]  word_count;
    logic        busy;
    logic        done;
    logic [39:0] result;
    logic [23:0] m_address;
    logic        m_read;
    logic        m_waitrequest;
    logic [31:0] m_readdata;
    logic        m_readdatavalid;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [16];
    int          waitCycles = 0;
    int          waitCnt = 0;
    int          rdvMode = 0;
    logic        pendValid = 1'b0;
    logic [31:0] rdData = 32'h0;
    logic [23:0] acceptLog [32];
    int          acceptCount = 0;
    int          readCycles = 0;
    int          stallCount = 0;
    int          stallViol = 0;
    int          doneSeen = 0;
    logic        prevStall = 1'b0;
    logic [23:0] prevAddr = 24'h0;

    short_pair_mac dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .base_addr       (base_addr),
        .word_count      (word_count),
        .busy            (busy),
        .done            (done),
        .result          (result),
        .m_address       (m_address),
        .m_read          (m_read),
        .m_waitrequest   (m_waitrequest),
        .m_readdata      (m_readdata),
        .m_readdatavalid (m_readdatavalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave: stall each read for waitCycles, then return data one cycle after acceptance.
    assign m_waitrequest   = m_read && (waitCnt < waitCycles);
    assign m_readdata      = rdData;
    assign m_readdatavalid = (rdvMode == 1) ? 1'b1 : (rdvMode == 2) ? 1'b0 : pendValid;

    always @(posedge clk) begin
        if (m_read) readCycles <= readCycles + 1;
        if (prevStall && (!m_read || m_address !== prevAddr)) stallViol <= stallViol + 1;
        prevStall <= m_read && m_waitrequest;
        prevAddr  <= m_address;
        if (m_read && m_waitrequest) begin
            waitCnt    <= waitCnt + 1;
            stallCount <= stallCount + 1;
            pendValid  <= 1'b0;
        end else if (m_read) begin
            waitCnt   <= 0;
            rdData    <= mem[m_address[5:2]];
            pendValid <= 1'b1;
            if (acceptCount < 32) acceptLog[acceptCount] <= m_address;
            acceptCount <= acceptCount + 1;
        end else begin
            pendValid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (done === 1'b1) doneSeen <= doneSeen + 1;
    end

    task automatic clearMonitors();
        acceptCount = 0;
        readCycles  = 0;
        stallCount  = 0;
        stallViol   = 0;
        doneSeen    = 0;
        waitCnt     = 0;
    endtask

    // Caller must be at a negedge; returns busy sampled one cycle after start is taken.
    task automatic applyStimulus(input logic [23:0] base, input logic [4:0] count,
                                 output logic busyAtStart);
        start      = 1'b1;
        base_addr  = base;
        word_count = count;
        @(negedge clk);
        start       = 1'b0;
        busyAtStart = busy;
    endtask

    task automatic waitDone(output int cycles, output bit timedOut, output logic [39:0] res,
                            output logic doneAfter, output logic busyAfter);
        cycles = 1;
        while (done !== 1'b1 && cycles < 300) begin
            @(negedge clk);
            cycles++;
        end
        timedOut = (done !== 1'b1);
        res      = result;
        @(negedge clk);
        doneAfter = done;
        busyAfter = busy;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, m_read, m_address, result} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state: busy=%b done=%b m_read=%b addr=%h result=%h, required all 0",
                     busy, done, m_read, m_address, result);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic bs, da, ba;
        int cyc;
        bit to;
        logic [39:0] res;
        mem[0] = 32'h0003_0002;
        mem[1] = 32'h0005_0004;
        clearMonitors();
        applyStimulus(24'h000000, 5'd2, bs);
        waitDone(cyc, to, res, da, ba);
        checks++;
        if (bs !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy_start: got %b want 1", bs); end
        checks++;
        if (to || cyc != 8) begin errors++; $display("[TB] FAIL basic_latency: got %0d cycles (timeout=%0d) want 8", cyc, to); end
        checks++;
        if (res !== 40'd26) begin errors++; $display("[TB] FAIL basic_result: got %0d want 26", $signed(res)); end
        checks++;
        if (da !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_pulse: done=%b next cycle want 0", da); end
        checks++;
        if (ba !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_end: busy=%b next cycle want 0", ba); end
        checks++;
        if (acceptCount != 2 || acceptLog[0] !== 24'h0 || acceptLog[1] !== 24'h4) begin
            errors++;
            $display("[TB] FAIL basic_addresses: count=%0d a0=%h a1=%h want 2,000000,000004",
                     acceptCount, acceptLog[0], acceptLog[1]);
        end
    endtask

    task automatic test_signed_extremes();
        logic bs, da, ba;
        int cyc;
        bit to;
        logic [39:0] res;
        mem[2] = 32'h8000_8000;
        mem[3] = 32'h7FFF_8000;
        clearMonitors();
        applyStimulus(24'h000008, 5'd1, bs);
        waitDone(cyc, to, res, da, ba);
        checks++;
        if (to || res !== 40'sd1073741824) begin
            errors++; $display("[TB] FAIL signed_max: got %0d (timeout=%0d) want 1073741824", $signed(res), to);
        end
        applyStimulus(24'h00000C, 5'd1, bs);
        waitDone(cyc, to, res, da, ba);
        checks++;
        if (to || res !== -40'sd1073709056) begin
            errors++; $display("[TB] FAIL signed_mixed: got %0d (timeout=%0d) want -1073709056", $signed(res), to);
        end
    endtask

    task automatic test_zero_count();
        logic bs, da, ba;
        int cyc;
        bit to;
        logic [39:0] res;
        clearMonitors();
        applyStimulus(24'h000010, 5'd0, bs);
        waitDone(cyc, to, res, da, ba);
        checks++;
        if (to || cyc != 1) begin errors++; $display("[TB] FAIL zero_latency: got %0d cycles (timeout=%0d) want 1", cyc, to); end
        checks++;
        if (res !== 40'd0) begin errors++; $display("[TB] FAIL zero_result: got %0d want 0", $signed(res)); end
        checks++;
        if (readCycles != 0) begin errors++; $display("[TB] FAIL zero_no_read: m_read high %0d cycles want 0", readCycles); end
    endtask

    task automatic test_waitrequest();
        logic bs, da, ba;
        int cyc;
        bit to;
        logic [39:0] res;
        clearMonitors();
        waitCycles = 3;
        applyStimulus(24'h000000, 5'd2, bs);
        waitDone(cyc, to, res, da, ba);
        waitCycles = 0;
        checks++;
        if (to || res !== 40'd26) begin errors++; $display("[TB] FAIL wait_result: got %0d (timeout=%0d) want 26", $signed(res), to); end
        checks++;
        if (stallCount != 6) begin errors++; $display("[TB] FAIL wait_stalls: got %0d stall cycles want 6", stallCount); end
        checks++;
        if (stallViol != 0) begin errors++; $display("[TB] FAIL wait_hold: %0d request changes under stall want 0", stallViol); end
    endtask

    task automatic test_constant_valid();
        logic bs, da, ba;
        int cyc;
        bit to;
        logic [39:0] res;
        for (int i = 4; i < 8; i++) mem[i] = 32'h0001_0001;
        clearMonitors();
        rdvMode = 1;
        applyStimulus(24'h000010, 5'd4, bs);
        waitDone(cyc, to, res, da, ba);
        rdvMode = 0;
        checks++;
        if (to || res !== 40'd4) begin errors++; $display("[TB] FAIL const_valid_result: got %0d (timeout=%0d) want 4", $signed(res), to); end
        checks++;
        if (acceptCount != 4) begin errors++; $display("[TB] FAIL const_valid_reads: got %0d reads want 4", acceptCount); end
    endtask

    task automatic test_reset_mid_job();
        logic bs, da, ba;
        int cyc;
        bit to;
        logic [39:0] res;
        mem[8] = 32'h0002_0003;
        clearMonitors();
        rdvMode = 2;
        applyStimulus(24'h000020, 5'd3, bs);
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || m_address !== 24'h000020) begin
            errors++; $display("[TB] FAIL abort_pre: busy=%b addr=%h want 1,000020", busy, m_address);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, m_read, m_address, result} !== '0) begin
            errors++;
            $display("[TB] FAIL abort_async: busy=%b done=%b m_read=%b addr=%h result=%h want all 0",
                     busy, done, m_read, m_address, result);
        end
        rdvMode = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (doneSeen != 0) begin errors++; $display("[TB] FAIL abort_no_done: done seen %0d times want 0", doneSeen); end
        applyStimulus(24'h000020, 5'd1, bs);
        waitDone(cyc, to, res, da, ba);
        checks++;
        if (to || res !== 40'd6) begin errors++; $display("[TB] FAIL abort_restart: got %0d (timeout=%0d) want 6", $signed(res), to); end
    endtask

    task automatic test_addr_wrap();
        logic bs, da, ba;
        int cyc;
        bit to;
        logic [39:0] res;
        mem[15] = 32'hFFFF_0002;
        mem[0]  = 32'h0006_0007;
        clearMonitors();
        applyStimulus(24'hFFFFFC, 5'd2, bs);
        waitDone(cyc, to, res, da, ba);
        checks++;
        if (acceptCount != 2 || acceptLog[0] !== 24'hFFFFFC || acceptLog[1] !== 24'h000000) begin
            errors++;
            $display("[TB] FAIL wrap_addresses: count=%0d a0=%h a1=%h want 2,fffffc,000000",
                     acceptCount, acceptLog[0], acceptLog[1]);
        end
        checks++;
        if (to || res !== 40'd40) begin errors++; $display("[TB] FAIL wrap_result: got %0d (timeout=%0d) want 40", $signed(res), to); end
    endtask

    initial begin
        start      = 1'b0;
        base_addr  = 24'h0;
        word_count = 5'd0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        test_reset();
        test_basic();
        test_signed_extremes();
        test_zero_count();
        test_waitrequest();
        test_constant_valid();
        test_reset_mid_job();
        test_addr_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
